// File: rtl/audio_if_pkg.sv
// Shared definitions for the audio sample writer: register indices, CTRL
// and STATUS bit positions, and the packed layout of the STATUS word.
// Optional feature macro used by the design: AUDIO_UNDERRUN_CNT_EN.
package audio_if_pkg;

   // Register window indices (Avalon-MM address)
   localparam logic [1:0] REG_DATA     = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_CTRL     = 2'd2;
   localparam logic [1:0] REG_UNDERRUN = 2'd3;

   // CTRL write bits: enable is stored, flush and ovf_clr are one-shot
   localparam int CTRL_ENABLE_BIT  = 0;
   localparam int CTRL_FLUSH_BIT   = 1;
   localparam int CTRL_OVF_CLR_BIT = 2;

   // STATUS bit positions (empty and full occupy bits 0 and 1)
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_MSB = 15;

   typedef struct packed {
      logic [31:STAT_COUNT_MSB+1]             rsvd_hi;
      logic [STAT_COUNT_MSB:STAT_COUNT_LSB]   count;
      logic [STAT_COUNT_LSB-1:STAT_OVF_BIT+1] rsvd_lo;
      logic                                   overflow;
      logic                                   full;
      logic                                   empty;
   } status_reg_t;

endpackage

// File: rtl/audio_write_interface_sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO. The entry at the read pointer is
// always presented on head_data; a pop simply advances the pointer.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   push, push_data   write request and sample (ignored when full)
//   pop               advance head (ignored when empty)
//   flush             empty the FIFO at the next edge; wins over push/pop
//   head_data         sample at the FIFO head
//   count/full/empty  occupancy, 0..DEPTH
// No overflow policy lives here; the caller decides what a refused push means.
module sample_fifo #(
   parameter int DATA_SIZE = 28,
   parameter int DEPTH     = 16,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   input  logic                 flush,
   output logic [DATA_SIZE-1:0] head_data,
   output logic [ADDR_W:0]      count,
   output logic                 full,
   output logic                 empty
);

   localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   // Pointers carry one extra bit so full and empty differ; they wrap mod 2*DEPTH.
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            do_push, do_pop;

   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      full     = (count == DEPTH_CNT);
      empty    = (count == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   assign head_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: empty pointers make its contents invisible.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/audio_write_interface.sv
// audio_write_interface: Avalon-MM slave that buffers CPU-written audio
// samples in a FIFO and drains them through an Avalon-ST source.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   chipselect/address/write/
//   writedata/read/read_data     register window (read_data: 1-cycle latency)
//   stream_valid/stream_data/
//   stream_ready                 sample output handshake
// Registers: 0 DATA (W), 1 STATUS (R), 2 CTRL (R/W), 3 UNDERRUN (R).
// Optional feature: define AUDIO_UNDERRUN_CNT_EN to build the saturating
// underrun counter at address 3; otherwise address 3 reads zero.
//
// Handshake: a sample transfers on a rising edge where stream_valid and
// stream_ready are both 1. stream_valid depends only on registered state
// (enable and FIFO occupancy), never on stream_ready, and stream_data holds
// the head sample steady until it is accepted.
module audio_write_interface
   import audio_if_pkg::*;
#(
   parameter int DATA_SIZE = 28,
   parameter int DEPTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 chipselect,
   input  logic [1:0]           address,
   input  logic                 write,
   input  logic [31:0]          writedata,
   input  logic                 read,
   output logic [31:0]          read_data,
   output logic                 stream_valid,
   output logic [DATA_SIZE-1:0] stream_data,
   input  logic                 stream_ready
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [ADDR_W:0] fifo_count;
   logic            fifo_full, fifo_empty;
   logic            push_req, ctrl_wr, fifo_push, ovf_push, flush, ovf_clr, pop;
   logic            enable_q, enable_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     read_data_q, read_data_d;
   status_reg_t     status;
   logic            unused_writedata;

   // Upper writedata bits are architecturally ignored.
   assign unused_writedata = ^writedata;

   assign push_req  = chipselect && write && (address == REG_DATA);
   assign ctrl_wr   = chipselect && write && (address == REG_CTRL);
   assign flush     = ctrl_wr && writedata[CTRL_FLUSH_BIT];
   assign ovf_clr   = ctrl_wr && writedata[CTRL_OVF_CLR_BIT];
   // Fullness is judged before this edge, so a same-cycle pop cannot make room.
   assign fifo_push = push_req && !fifo_full;
   assign ovf_push  = push_req && fifo_full;

   assign stream_valid = enable_q && !fifo_empty;
   assign pop          = stream_valid && stream_ready;

   sample_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (writedata[DATA_SIZE-1:0]),
      .pop       (pop),
      .flush     (flush),
      .head_data (stream_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef AUDIO_UNDERRUN_CNT_EN
   logic [31:0] underrun_q, underrun_d;

   // Counts cycles where downstream is ready but nothing is available.
   always_comb begin
      underrun_d = underrun_q;
      if (ovf_clr)
         underrun_d = '0;
      else if (enable_q && fifo_empty && stream_ready && (underrun_q != 32'hFFFF_FFFF))
         underrun_d = underrun_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) underrun_q <= '0;
      else          underrun_q <= underrun_d;
   end
`endif

   always_comb begin
      status          = '0;
      status.empty    = fifo_empty;
      status.full     = fifo_full;
      status.overflow = overflow_q;
      // Zero-extended for small DEPTH; only the low byte fits the field.
      status.count    = 8'(fifo_count);
   end

   always_comb begin
      enable_d    = enable_q;
      overflow_d  = overflow_q;
      read_data_d = read_data_q;

      if (ctrl_wr) enable_d = writedata[CTRL_ENABLE_BIT];

      // A same-cycle refused push keeps the flag set despite a clear.
      if (ovf_push)     overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;

      if (chipselect && read) begin
         case (address)
            REG_DATA:     read_data_d = '0;
            REG_STATUS:   read_data_d = status;
            REG_CTRL:     read_data_d = {31'b0, enable_q};
`ifdef AUDIO_UNDERRUN_CNT_EN
            REG_UNDERRUN: read_data_d = underrun_q;
`else
            REG_UNDERRUN: read_data_d = '0;
`endif
            default:      read_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable_q    <= 1'b0;
         overflow_q  <= 1'b0;
         read_data_q <= '0;
      end else begin
         enable_q    <= enable_d;
         overflow_q  <= overflow_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data = read_data_q;

endmodule

// File: tb/tb_audio_write_interface.sv
// Directed bench for audio_write_interface: reset, single transfer,
// overflow, streaming with wrap, flush, mid-transfer reset, underrun counter.
module tb_audio_write_interface;

   localparam int W = 28;

   logic          clk;
   logic          reset_n;
   logic          chipselect;
   logic [1:0]    address;
   logic          write;
   logic [31:0]   writedata;
   logic          read;
   logic [31:0]   read_data;
   logic          stream_valid;
   logic [W-1:0]  stream_data;
   logic          stream_ready;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   audio_write_interface #(.DATA_SIZE(W), .DEPTH(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .chipselect   (chipselect),
      .address      (address),
      .write        (write),
      .writedata    (writedata),
      .read         (read),
      .read_data    (read_data),
      .stream_valid (stream_valid),
      .stream_data  (stream_data),
      .stream_ready (stream_ready)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Records every accepted sample; inputs settle 1ns after posedge.
   always @(negedge clk) begin
      if (reset_n && stream_valid && stream_ready) got_q.push_back(stream_data);
   end

   // ---------------- drivers ----------------
   // All drivers start and end 1ns after a rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = read_data;
   endtask

   task automatic wait_drain(output bit timed_out);
      int n;
      n = 0;
      stream_ready = 1'b1;
      while (stream_valid === 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      timed_out = (stream_valid !== 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      checks++;
      if (stream_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", stream_valid); end
      checks++;
      if (read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=00000000", read_data); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL reset_status got=%h exp=00000001", rd); end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=00000000", rd); end
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_data_read got=%h exp=00000000", rd); end
   endtask

   task automatic test_single();
      logic [31:0] rd;
      bus_write(2'd2, 32'h1);
      stream_ready = 1'b1;
      got_q.delete();
      bus_write(2'd0, 32'hF123_4567);   // upper nibble must be ignored
      checks++;
      if (stream_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", stream_valid); end
      checks++;
      if (stream_data !== 28'h123_4567) begin failures++; $display("FAIL single_data got=%h exp=1234567", stream_data); end
      @(posedge clk); #1;
      checks++;
      if (stream_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%b exp=0", stream_valid); end
      checks++;
      if (got_q.size() !== 1) begin failures++; $display("FAIL single_xfer_count got=%0d exp=1", got_q.size()); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL single_status got=%h exp=00000001", rd); end
      @(posedge clk); #1;
      checks++;
      if (read_data !== 32'h0000_0001) begin failures++; $display("FAIL read_data_hold got=%h exp=00000001", read_data); end
      got_q.delete();
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bit          to;
      stream_ready = 1'b0;
      bus_write(2'd2, 32'h0);
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         bus_write(2'd0, 32'(i));
         exp_q.push_back(W'(i));
      end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_1002) begin failures++; $display("FAIL full_status got=%h exp=00001002", rd); end
      bus_write(2'd0, 32'h0ABC_DEF0);
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_1006) begin failures++; $display("FAIL ovf_status got=%h exp=00001006", rd); end
      checks++;
      if (stream_valid !== 1'b0) begin failures++; $display("FAIL disabled_valid got=%b exp=0", stream_valid); end
      bus_write(2'd2, 32'h4);           // ovf_clr, enable stays 0
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_1002) begin failures++; $display("FAIL ovf_clr_status got=%h exp=00001002", rd); end
      // Enable, then push into the full FIFO while a pop is happening.
      stream_ready = 1'b1;
      bus_write(2'd2, 32'h1);
      bus_write(2'd0, 32'h0ABC_DEF0);
      wait_drain(to);
      checks++;
      if (to) begin failures++; $display("FAIL ovf_drain_timeout got=valid exp=idle"); end
      checks++;
      if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0005) begin failures++; $display("FAIL ovf_sticky got=%h exp=00000005", rd); end
      bus_write(2'd2, 32'h5);
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL ovf_cleared got=%h exp=00000001", rd); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [W-1:0] v;
      bit           to;
      stream_ready = 1'b0;
      bus_write(2'd2, 32'h0);
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         v = W'(28'h0A0_0000 + i * 28'h012_3457);
         bus_write(2'd0, 32'(v));
         exp_q.push_back(v);
      end
      stream_ready = 1'b1;
      bus_write(2'd2, 32'h1);
      for (int i = 5; i < 25; i++) begin
         v = W'(28'h0A0_0000 + i * 28'h012_3457);
         bus_write(2'd0, 32'(v));
         exp_q.push_back(v);
      end
      stream_ready = 1'b0;
      checks++;
      if (got_q.size() !== 20) begin failures++; $display("FAIL b2b_pops got=%0d exp=20", got_q.size()); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0500) begin failures++; $display("FAIL b2b_count got=%h exp=00000500", rd); end
      wait_drain(to);
      checks++;
      if (to) begin failures++; $display("FAIL b2b_drain_timeout got=valid exp=idle"); end
      checks++;
      if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_total got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_flush();
      logic [31:0] rd;
      stream_ready = 1'b0;
      bus_write(2'd2, 32'h0);
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h0777_0000 + 32'(i));
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0900) begin failures++; $display("FAIL flush_pre_count got=%h exp=00000900", rd); end
      stream_ready = 1'b1;
      bus_write(2'd2, 32'h3);           // enable + flush
      checks++;
      if (stream_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", stream_valid); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL flush_status got=%h exp=00000001", rd); end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL flush_enable got=%h exp=00000001", rd); end
      stream_ready = 1'b0;
      bus_write(2'd0, 32'h05A5_A5A5);
      checks++;
      if (stream_valid !== 1'b1 || stream_data !== 28'h5A5_A5A5) begin
         failures++; $display("FAIL flush_new_head got=%b/%h exp=1/5a5a5a5", stream_valid, stream_data);
      end
      bus_write(2'd2, 32'h2);           // disable + flush
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      stream_ready = 1'b0;
      for (int i = 0; i < 10; i++) bus_write(2'd0, 32'h0100_0000 + 32'(i));
      bus_write(2'd2, 32'h1);
      checks++;
      if (stream_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", stream_valid); end
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      checks++;
      if (stream_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", stream_valid); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin failures++; $display("FAIL mid_status got=%h exp=00000001", rd); end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL mid_ctrl got=%h exp=00000000", rd); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_underrun();
      logic [31:0] rd;
      logic [31:0] exp_cnt;
`ifdef AUDIO_UNDERRUN_CNT_EN
      exp_cnt = 32'd7;
`else
      exp_cnt = 32'd0;
`endif
      stream_ready = 1'b0;
      // Read and write CTRL in the same cycle: old value returned, new stored.
      chipselect = 1'b1; write = 1'b1; read = 1'b1; address = 2'd2; writedata = 32'h5;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      checks++;
      if (read_data !== 32'h0) begin failures++; $display("FAIL rw_same_old got=%h exp=00000000", read_data); end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h1) begin failures++; $display("FAIL rw_same_new got=%h exp=00000001", rd); end
      stream_ready = 1'b1;
      repeat (7) @(posedge clk);
      #1 stream_ready = 1'b0;
      bus_read(2'd3, rd);
      checks++;
      if (rd !== exp_cnt) begin failures++; $display("FAIL underrun_count got=%h exp=%h", rd, exp_cnt); end
      bus_write(2'd2, 32'h5);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL underrun_clear got=%h exp=00000000", rd); end
   endtask

   initial begin
      reset_n = 1'b0; chipselect = 1'b0; address = 2'd0; write = 1'b0;
      writedata = 32'h0; read = 1'b0; stream_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_underrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
